fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-channel forwarding mux.
- Owns the destination-register scoreboard for the MEM, WB and retire slots, and drives per-operand forwarding selects and forwarded operand data for NUM_SRC source channels in EX.
- Detects load-use hazards and stalls for a configurable number of cycles.
- Sits between the ID/EX pipeline register and the ALU operand inputs; stall/bubble go to the hazard control of IF/ID and ID/EX.

Parameters:
- XLEN, 32, datapath width.
- AW, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (1..3).
- LOAD_STALLS, 1, stall cycles inserted per load-use hazard (1..3).
- REGFILE_BYPASS, 1, 1 = register file is write-through (no retire slot); 0 = retire slot forwards WB data one extra cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  squash the EX instruction (branch/exception).
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  AW  EX destination register.
- ex_regwrite  in  1  EX writes the register file.
- ex_memtoreg  in  1  EX is a load.
- ex_rs_addr  in  NUM_SRC*AW  EX source addresses, channel i at [i*AW +: AW].
- ex_rs_data  in  NUM_SRC*XLEN  register-file read data for EX sources.
- id_rs_addr  in  NUM_SRC*AW  ID source addresses.
- id_rs_used  in  NUM_SRC  ID actually reads that source.
- mem_alu_res  in  XLEN  ALU result in MEM.
- wb_alu_res  in  XLEN  ALU result in WB.
- wb_read_data  in  XLEN  load data in WB.
- ex_op_data  out  NUM_SRC*XLEN  forwarded operands.
- fwd_sel  out  NUM_SRC*2  per channel: 00 regfile, 01 MEM, 10 WB, 11 retire.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  zero ID/EX control next edge (equals stall).

Behaviour:
- Scoreboard slots MEM, WB, RET each hold {we, rd, ld}; RET also holds a registered XLEN value. RET exists only when REGFILE_BYPASS=0; otherwise RET.we is tied to 0.
- Reset (async) clears all slots (we=0, rd=0, ld=0, RET data=0) and the stall counter to 0.
- After reset: stall=0, bubble=0, fwd_sel=0, ex_op_data=ex_rs_data.

Per rising edge:
- MEM <= {ex_valid & ex_regwrite & ~stall & ~flush, ex_rd, ex_memtoreg}.
- WB <= MEM.
- RET <= {WB.we, WB.rd, WB data}, where WB data = wb_read_data if WB.ld, else wb_alu_res.
- Slots advance even during stall: older instructions always drain.

Forwarding (combinational, per channel i, addr = ex_rs_addr[i]):
- addr==0: sel 00, never forwarded.
- Else MEM.we & MEM.rd==addr & ~MEM.ld: sel 01, mem_alu_res.
- Else WB.we & WB.rd==addr: sel 10, wb_read_data if WB.ld, else wb_alu_res.
- Else RET.we & RET.rd==addr: sel 11, RET data.
- Else sel 00, ex_rs_data[i].
- Priority is MEM > WB > RET (youngest wins).
- MEM.ld match never forwards; the stall guarantees it is not consumed.

Load-use detect (combinational):
- detect = ex_valid & ex_regwrite & ex_memtoreg & ex_rd!=0 & any channel i with id_rs_used[i] & id_rs_addr[i]==ex_rd.

Stall counter:
- stall = ~flush & (detect | cnt!=0).
- On an edge with cnt==0 and stall: cnt <= LOAD_STALLS-1.
- On an edge with cnt!=0: cnt <= cnt-1.
- flush forces cnt <= 0 on the edge.

Boundary cases:
- Simultaneous flush and detect: flush wins; stall=0, and the EX instruction is not captured into MEM.
- LOAD_STALLS>1 with REGFILE_BYPASS=1: the load reaches the register file before the dependent enters EX; the regfile path is then correct.
- Asserting reset mid-stall aborts the stall immediately; slots are cleared.
- Same rd in MEM and WB: MEM value selected.
- rd=x0 writes are tracked but never matched.

Test Plan:
1. ALU x5=7 followed by a dependent on x5 in the next instruction → fwd_sel[0]=01, ex_op_data[0]=7. One instruction later, WB match → sel 10, value 7.
2. lw x6 in EX with ID reading rs2=x6, LOAD_STALLS=1 → stall=bubble=1 for exactly one cycle. Two cycles later the dependent in EX gets sel 10 with wb_read_data=0xDEADBEEF.
3. LOAD_STALLS=3: same load-use → stall high for 3 consecutive cycles, then 0. Flush asserted in the 2nd stall cycle → stall drops in that same cycle; cnt=0 next cycle.
4. MEM and WB both write x9 (values 1 and 2), EX reads x9 on both channels → both channels sel 01, value 1. Any operand reading x0 → sel 00 and regfile data, even when MEM.rd=0 with we=1.
5. REGFILE_BYPASS=0: write x3=0x55 retires from WB, dependent in EX one cycle later → sel 11, 0x55. With REGFILE_BYPASS=1 the same sequence → sel 00.
6. Reset asserted asynchronously mid-stream → outputs return immediately to reset values; first post-reset instruction sees no forwarding.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the EX stage.
// Tracks destination registers in the MEM, WB and (optional) retire slots,
// selects the youngest in-flight producer per source channel, and holds
// IF/ID for a configurable number of cycles on a load-use dependency.
module fwd_hazard_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned AW             = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned LOAD_STALLS    = 1,
  parameter int unsigned REGFILE_BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    ex_valid,
  input  logic [AW-1:0]           ex_rd,
  input  logic                    ex_regwrite,
  input  logic                    ex_memtoreg,
  input  logic [NUM_SRC*AW-1:0]   ex_rs_addr,
  input  logic [NUM_SRC*XLEN-1:0] ex_rs_data,
  input  logic [NUM_SRC*AW-1:0]   id_rs_addr,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [XLEN-1:0]         mem_alu_res,
  input  logic [XLEN-1:0]         wb_alu_res,
  input  logic [XLEN-1:0]         wb_read_data,
  output logic [NUM_SRC*XLEN-1:0] ex_op_data,
  output logic [NUM_SRC*2-1:0]    fwd_sel,
  output logic                    stall,
  output logic                    bubble
);

  typedef enum logic [1:0] {
    SelRegfile = 2'b00,
    SelMem     = 2'b01,
    SelWb      = 2'b10,
    SelRet     = 2'b11
  } fwdSel_t;

  localparam logic [1:0] StallReload = 2'(LOAD_STALLS - 1);
  localparam logic       RetEnabled  = (REGFILE_BYPASS == 0);

  logic            memWe, memLd;
  logic [AW-1:0]   memRd;
  logic            wbWe, wbLd;
  logic [AW-1:0]   wbRd;
  logic            retWe;
  logic [AW-1:0]   retRd;
  logic [XLEN-1:0] retData;
  logic [1:0]      stallCnt;
  logic            idHit;
  logic            loadUse;
  logic [XLEN-1:0] wbData;

  // Value the WB instruction will write back.
  always_comb begin
    wbData = wbLd ? wb_read_data : wb_alu_res;
  end

  // Destination scoreboard; slots keep draining even while ID is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memWe   <= 1'b0;
      memRd   <= '0;
      memLd   <= 1'b0;
      wbWe    <= 1'b0;
      wbRd    <= '0;
      wbLd    <= 1'b0;
      retWe   <= 1'b0;
      retRd   <= '0;
      retData <= '0;
    end else begin
      memWe   <= ex_valid & ex_regwrite & ~stall & ~flush;
      memRd   <= ex_rd;
      memLd   <= ex_memtoreg;
      wbWe    <= memWe;
      wbRd    <= memRd;
      wbLd    <= memLd;
      retWe   <= RetEnabled & wbWe;
      retRd   <= wbRd;
      retData <= wbData;
    end
  end

  // Load-use detection and stall/bubble generation; flush overrides stall.
  always_comb begin
    idHit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs_addr[i*AW +: AW] == ex_rd)) idHit = 1'b1;
    end
    loadUse = ex_valid & ex_regwrite & ex_memtoreg & (ex_rd != '0) & idHit;
    stall   = ~flush & (loadUse | (stallCnt != '0));
    bubble  = stall;
  end

  // Remaining stall cycles after the first one of a load-use hazard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (flush) begin
      stallCnt <= '0;
    end else if (stallCnt != '0) begin
      stallCnt <= stallCnt - 2'd1;
    end else if (stall) begin
      stallCnt <= StallReload;
    end
  end

  // Per-channel forwarding select, youngest producer first; a load in MEM
  // is skipped because its data is not available yet.
  always_comb begin
    fwd_sel    = '0;
    ex_op_data = ex_rs_data;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (ex_rs_addr[i*AW +: AW] != '0) begin
        if (memWe && !memLd && (memRd == ex_rs_addr[i*AW +: AW])) begin
          fwd_sel[i*2 +: 2]       = SelMem;
          ex_op_data[i*XLEN +: XLEN] = mem_alu_res;
        end else if (wbWe && (wbRd == ex_rs_addr[i*AW +: AW])) begin
          fwd_sel[i*2 +: 2]       = SelWb;
          ex_op_data[i*XLEN +: XLEN] = wbData;
        end else if (retWe && (retRd == ex_rs_addr[i*AW +: AW])) begin
          fwd_sel[i*2 +: 2]       = SelRet;
          ex_op_data[i*XLEN +: XLEN] = retData;
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances (1 stall/write-through
// and 3 stalls/retire slot) share stimulus; a pipeline-history model predicts
// each cycle's outputs and a negedge monitor compares them.
module tb_fwd_hazard_unit;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, flush, ex_valid, ex_regwrite, ex_memtoreg;
  logic [AW-1:0]        ex_rd;
  logic [NS*AW-1:0]     ex_rs_addr, id_rs_addr;
  logic [NS*XLEN-1:0]   ex_rs_data;
  logic [NS-1:0]        id_rs_used;
  logic [XLEN-1:0]      mem_alu_res, wb_alu_res, wb_read_data;
  logic [NS*XLEN-1:0]   opA, opB;
  logic [NS*2-1:0]      selA, selB;
  logic                 stallA, stallB, bubbleA, bubbleB;

  fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NS), .LOAD_STALLS(1), .REGFILE_BYPASS(1)) dutA (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_rs_addr(ex_rs_addr),
    .ex_rs_data(ex_rs_data), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .mem_alu_res(mem_alu_res), .wb_alu_res(wb_alu_res), .wb_read_data(wb_read_data),
    .ex_op_data(opA), .fwd_sel(selA), .stall(stallA), .bubble(bubbleA));

  fwd_hazard_unit #(.XLEN(XLEN), .AW(AW), .NUM_SRC(NS), .LOAD_STALLS(3), .REGFILE_BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_rs_addr(ex_rs_addr),
    .ex_rs_data(ex_rs_data), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .mem_alu_res(mem_alu_res), .wb_alu_res(wb_alu_res), .wb_read_data(wb_read_data),
    .ex_op_data(opB), .fwd_sel(selB), .stall(stallB), .bubble(bubbleB));

  typedef struct {
    bit        rst, flush, valid, regwrite, memtoreg;
    bit [4:0]  rd;
    bit [9:0]  exAddr, idAddr;
    bit [1:0]  idUsed;
    bit [63:0] exData;
    bit [31:0] memAlu, wbAlu, wbRd;
  } stim_t;

  typedef struct {
    bit        we;
    bit [4:0]  rd;
    bit        ld;
  } wr_t;

  typedef struct {
    bit [1:0]   stall;
    bit [7:0]   sel;
    bit [127:0] data;
  } exp_t;

  // Model state per instance: hist[d][age], age 0 = instruction now in MEM.
  wr_t       hist[2][3];
  bit [31:0] retVal[2];
  int        remain[2];
  bit        prevStall[2];
  stim_t     cur;
  exp_t      sbq[$];
  int        errors = 0;
  int        checks = 0;

  function automatic int stallsOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 3; a++) hist[d][a] = '{we: 1'b0, rd: 5'd0, ld: 1'b0};
      retVal[d] = '0;
      remain[d] = 0;
    end
  endfunction

  // One clock edge worth of pipeline advance, given the inputs that were held.
  function automatic void modelEdge(input stim_t s);
    for (int d = 0; d < 2; d++) begin
      retVal[d]     = hist[d][1].ld ? s.wbRd : s.wbAlu;
      hist[d][2]    = hist[d][1];
      hist[d][1]    = hist[d][0];
      hist[d][0].we = s.valid & s.regwrite & ~prevStall[d] & ~s.flush;
      hist[d][0].rd = s.rd;
      hist[d][0].ld = s.memtoreg;
      if (s.flush) remain[d] = 0;
      else if (remain[d] > 0) remain[d] = remain[d] - 1;
      else if (prevStall[d]) remain[d] = stallsOf(d) - 1;
    end
  endfunction

  function automatic void predict(input int d, input stim_t s, output bit st,
                                  output bit [3:0] sel, output bit [63:0] data);
    bit       hit = 1'b0;
    bit       found;
    bit [4:0] addr;
    int       maxAge = (d == 0) ? 1 : 2;
    for (int c = 0; c < NS; c++)
      if (s.idUsed[c] && s.idAddr[c*5 +: 5] == s.rd) hit = 1'b1;
    st = !s.flush && ((s.valid && s.regwrite && s.memtoreg && s.rd != 0 && hit) || remain[d] != 0);
    sel  = '0;
    data = s.exData;
    for (int c = 0; c < NS; c++) begin
      addr  = s.exAddr[c*5 +: 5];
      found = 1'b0;
      if (addr != 0) begin
        for (int a = 0; a <= maxAge; a++) begin
          if (!found && hist[d][a].we && hist[d][a].rd == addr && !(a == 0 && hist[d][a].ld)) begin
            found = 1'b1;
            sel[c*2 +: 2] = 2'(a + 1);
            if (a == 0) data[c*32 +: 32] = s.memAlu;
            else if (a == 1) data[c*32 +: 32] = hist[d][1].ld ? s.wbRd : s.wbAlu;
            else data[c*32 +: 32] = retVal[d];
          end
        end
      end
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.exData = {$urandom(), $urandom()};
    s.memAlu = $urandom();
    s.wbAlu  = $urandom();
    s.wbRd   = $urandom();
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s = idle();
    s.rst      = ($urandom_range(0, 39) == 0);
    s.flush    = ($urandom_range(0, 7) == 0);
    s.valid    = ($urandom_range(0, 3) != 0);
    s.regwrite = ($urandom_range(0, 4) != 0);
    s.memtoreg = ($urandom_range(0, 2) == 0);
    s.rd       = 5'($urandom_range(0, 7));
    s.exAddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    s.idAddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    s.idUsed   = 2'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset        = s.rst;
    flush        = s.flush;
    ex_valid     = s.valid;
    ex_regwrite  = s.regwrite;
    ex_memtoreg  = s.memtoreg;
    ex_rd        = s.rd;
    ex_rs_addr   = s.exAddr;
    ex_rs_data   = s.exData;
    id_rs_addr   = s.idAddr;
    id_rs_used   = s.idUsed;
    mem_alu_res  = s.memAlu;
    wb_alu_res   = s.wbAlu;
    wb_read_data = s.wbRd;
  endtask

  // Advance one cycle, apply new inputs just after the edge, queue the prediction.
  task automatic runCycle(input stim_t s);
    exp_t      e;
    bit        st;
    bit [3:0]  sl;
    bit [63:0] dt;
    @(posedge clk);
    if (!cur.rst) modelEdge(cur);
    #1;
    cur = s;
    drive(s);
    if (s.rst) modelReset();
    for (int d = 0; d < 2; d++) begin
      predict(d, s, st, sl, dt);
      e.stall[d]           = st;
      e.sel[d*4 +: 4]      = sl;
      e.data[d*64 +: 64]   = dt;
      prevStall[d]         = st;
    end
    sbq.push_back(e);
  endtask

  function automatic void chk(input string name, input int d, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, got, want);
    end
  endfunction

  // Monitor: outputs are stable by the falling edge after each input update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("stall",      0, 64'(stallA),  64'(e.stall[0]));
        chk("bubble",     0, 64'(bubbleA), 64'(e.stall[0]));
        chk("fwd_sel",    0, 64'(selA),    64'(e.sel[3:0]));
        chk("ex_op_data", 0, opA,          e.data[63:0]);
        chk("stall",      1, 64'(stallB),  64'(e.stall[1]));
        chk("bubble",     1, 64'(bubbleB), 64'(e.stall[1]));
        chk("fwd_sel",    1, 64'(selB),    64'(e.sel[7:4]));
        chk("ex_op_data", 1, opB,          e.data[127:64]);
      end
    end
  end

  initial begin
    stim_t s;
    cur = idle();
    cur.rst = 1'b1;
    prevStall[0] = 1'b0;
    prevStall[1] = 1'b0;
    modelReset();
    drive(cur);

    s = idle(); s.rst = 1'b1; runCycle(s); runCycle(s);

    // ALU write x5 then dependents in MEM, WB, retire distance
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5; runCycle(s);
    s = idle(); s.exAddr[4:0] = 5; s.memAlu = 7; runCycle(s);
    s = idle(); s.exAddr[4:0] = 5; s.wbAlu = 7; runCycle(s);
    s = idle(); s.exAddr[4:0] = 5; runCycle(s);

    // Load-use on x6 via channel 1, then dependents on x6
    s = idle(); s.valid = 1; s.regwrite = 1; s.memtoreg = 1; s.rd = 6;
    s.idAddr[9:5] = 6; s.idUsed = 2'b10; runCycle(s);
    for (int k = 0; k < 5; k++) begin
      s = idle(); s.exAddr[9:5] = 6; s.wbRd = 32'hDEADBEEF; runCycle(s);
    end

    // Load-use, then flush in the second stall cycle
    s = idle(); s.valid = 1; s.regwrite = 1; s.memtoreg = 1; s.rd = 7;
    s.idAddr[4:0] = 7; s.idUsed = 2'b01; runCycle(s);
    s = idle(); s.flush = 1; runCycle(s);
    s = idle(); runCycle(s); runCycle(s);

    // Simultaneous flush and load-use
    s = idle(); s.valid = 1; s.regwrite = 1; s.memtoreg = 1; s.rd = 7; s.flush = 1;
    s.idAddr[4:0] = 7; s.idUsed = 2'b01; runCycle(s);
    s = idle(); s.exAddr = {5'd7, 5'd7}; runCycle(s);

    // x9 written twice, both channels read x9; then x0 write/read
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 9; runCycle(s);
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 9; runCycle(s);
    s = idle(); s.exAddr = {5'd9, 5'd9}; s.memAlu = 1; s.wbAlu = 2;
    s.valid = 1; s.regwrite = 1; s.rd = 0; runCycle(s);
    s = idle(); s.exAddr = {5'd0, 5'd0}; runCycle(s);

    // x3 = 0x55 retiring from WB
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 3; runCycle(s);
    s = idle(); runCycle(s);
    s = idle(); s.wbAlu = 32'h55; runCycle(s);
    s = idle(); s.exAddr[4:0] = 3; runCycle(s);

    // Asynchronous reset mid-stall with a forwardable write in flight
    s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 2; runCycle(s);
    s = idle(); s.valid = 1; s.regwrite = 1; s.memtoreg = 1; s.rd = 4;
    s.idAddr[4:0] = 4; s.idUsed = 2'b01; s.exAddr[4:0] = 2; runCycle(s);
    s = idle(); s.rst = 1; s.exAddr = {5'd2, 5'd4}; runCycle(s);
    s = idle(); s.exAddr = {5'd2, 5'd4}; runCycle(s);

    for (int k = 0; k < 2000; k++) runCycle(randStim());

    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
